clock_time_set_ctrl: RTL
========================

Name: clock_time_set_ctrl

Overview:
Input-side companion to digital_clock_top. The clock top drives the six 7-segment outputs; this block takes the two raw push-buttons (mode, inc) and lets the user edit hours and minutes. It captures the running time, edits it in shadow registers, then issues a one-cycle load to the hour/minute/second counters, with seconds forced to 0. While editing it asserts set_active so the counters freeze.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed before a button level is accepted
REPEAT_CYCLES, 50000000, hold time of inc before auto-repeat, and the period between repeated increments
TIMEOUT_CYCLES, 500000000, idle cycles in an edit state before abandoning the edit without loading
CNT_W, 32, width of the internal debounce/repeat/timeout counters

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
btn_mode  input  1  raw, asynchronous, bouncy mode button; high = pressed
btn_inc  input  1  raw, asynchronous, bouncy increment button; high = pressed
cur_hour  input  5  running hour from the counters, binary 0..23
cur_min  input  6  running minute from the counters, binary 0..59
set_active  output  1  high in any edit state; counters must hold
field_sel  output  2  00 none, 01 hour selected, 10 minute selected
load  output  1  one-cycle pulse; counters take load_hour/load_min/load_sec
load_hour  output  5  edited hour, binary
load_min  output  6  edited minute, binary
load_sec  output  6  constant 0

Behaviour:
- Reset (rst high at a clk edge): state RUN.
  - set_active=0, field_sel=00, load=0.
  - load_hour=0, load_min=0, load_sec=0.
  - Synchronizers, debounced levels and all counters cleared.
- Reset mid-edit abandons the edit: no load pulse is issued.
- Each button path:
  - 2-FF synchronizer.
  - Debouncer: the debounced level flips on the edge at which the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears the count.
  - Press pulse = debounced rising edge, registered.
  - Latency, raw rising edge (held clean) to press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Bounces shorter than DEBOUNCE_CYCLES never produce a pulse.
- Auto-repeat on inc only:
  - While debounced inc stays high, an extra inc pulse is generated every REPEAT_CYCLES cycles after the press pulse.
  - Repeat count clears on release.
- FSM states: RUN, SET_HOUR, SET_MIN, COMMIT.
  - RUN:
    - mode press -> SET_HOUR; edit_hour<=cur_hour and edit_min<=cur_min, sampled in that same cycle.
    - inc ignored.
  - SET_HOUR:
    - field_sel=01.
    - inc: edit_hour <= (edit_hour==23) ? 0 : edit_hour+1.
    - mode press -> SET_MIN.
  - SET_MIN:
    - field_sel=10.
    - inc: edit_min <= (edit_min==59) ? 0 : edit_min+1.
    - mode press -> COMMIT.
  - COMMIT:
    - Lasts exactly one cycle: load=1, load_hour=edit_hour, load_min=edit_min, load_sec=0, set_active=1.
    - Next state RUN.
- set_active is high in SET_HOUR, SET_MIN and COMMIT; it is registered, so it rises the cycle after the mode press pulse.
- Hour/minute increments never carry between fields.
- Simultaneous mode and inc pulses in the same cycle: mode wins; the inc is discarded.
- Timeout:
  - The idle counter clears on any press (mode or inc, including repeats) and on state entry.
  - Reaching TIMEOUT_CYCLES in SET_HOUR or SET_MIN -> RUN with no load; counters resume from their frozen value.
- load_hour/load_min hold their last committed values between loads.

Decomposition:
- Package clock_pkg:
  - state enum {RUN, SET_HOUR, SET_MIN, COMMIT}.
  - MAX_HOUR=23, MAX_MIN=59.
  - HOUR_W=5, MIN_W=6, SEC_W=6.
  - field_sel encodings.
- Sub-module btn_debounce: synchronizer, debouncer and press-pulse generator, parameterised by DEBOUNCE_CYCLES and CNT_W; instantiated twice.
- Auto-repeat and the FSM stay in the top.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, TIMEOUT_CYCLES=200, clk period 10.)
- Reset: rst high 5 cycles -> all outputs 0, field_sel=00. Toggle btn_inc while in RUN -> load never pulses.
- Bounce rejection: btn_mode pulses high 3 cycles, low 2 cycles, repeated 5 times, then held high -> exactly one transition to SET_HOUR, 7 cycles after the final clean rising edge.
- Full edit: cur_hour=22, cur_min=58; mode, inc x3, mode, inc x2, mode -> a single load pulse with load_hour=1, load_min=0, load_sec=0, then RUN with set_active=0.
- Auto-repeat: in SET_MIN from 10, hold inc clean for 40 cycles after its press pulse -> edit_min=15 (1 press + 4 repeats). Committing gives load_min=15.
- Simultaneous/priority: in SET_HOUR, raise mode and inc in the same cycle and hold both -> state SET_MIN, edit_hour unchanged.
- Timeout and reset: enter SET_HOUR, idle 200 cycles -> RUN with no load. Enter SET_MIN and assert rst -> RUN, no load, load_hour/load_min=0.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared types and constants for the clock time-set controller.
//   state_e     : edit FSM states
//   HOUR_W/MIN_W/SEC_W : binary widths of the time fields
//   MAX_HOUR/MAX_MIN   : wrap points for the edited fields
//   FSEL_*      : field_sel encodings
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } state_e;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

  localparam logic [1:0] FSEL_NONE = 2'b00;
  localparam logic [1:0] FSEL_HOUR = 2'b01;
  localparam logic [1:0] FSEL_MIN  = 2'b10;

endpackage

// File: rtl/clock_time_set_ctrl_if.sv
// clock_time_set_ctrl_if: link between the time-set controller and the
// hour/minute/second counters.
//   cur_hour/cur_min : running time from the counters
//   set_active       : counters hold while high
//   field_sel        : 00 none, 01 hour, 10 minute
//   load             : one-cycle load strobe for load_hour/load_min/load_sec
// master = controller side, slave = counter side.
interface clock_time_set_ctrl_if import clock_pkg::*; ();

  logic [HOUR_W-1:0] cur_hour;
  logic [MIN_W-1:0]  cur_min;
  logic              set_active;
  logic [1:0]        field_sel;
  logic              load;
  logic [HOUR_W-1:0] load_hour;
  logic [MIN_W-1:0]  load_min;
  logic [SEC_W-1:0]  load_sec;

  modport master (
    input  cur_hour, cur_min,
    output set_active, field_sel, load, load_hour, load_min, load_sec
  );

  modport slave (
    output cur_hour, cur_min,
    input  set_active, field_sel, load, load_hour, load_min, load_sec
  );

endinterface

// File: rtl/clock_time_set_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, counting debouncer and press-pulse
// generator for one raw push-button.
//   clk, rst : clock, synchronous active-high reset
//   btn_raw  : raw asynchronous button, high = pressed
//   level    : debounced button level
//   press    : one-cycle pulse on the debounced rising edge (registered)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    cnt_d      = '0;
    // Count consecutive disagreeing samples; the level flips on the edge
    // that sees the DEBOUNCE_CYCLES-th one, any agreeing sample restarts.
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    deb_prev_d = deb_q;
    press_d    = deb_q & ~deb_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      cnt_q      <= cnt_d;
    end
  end

  assign level = deb_q;
  assign press = press_q;

endmodule

// File: rtl/clock_time_set_ctrl.sv
// clock_time_set_ctrl: two-button hour/minute editor for the digital clock.
//   clk, rst  : clock, synchronous active-high reset
//   btn_mode  : raw mode button (enter edit / next field / commit)
//   btn_inc   : raw increment button, auto-repeats while held
//   bus       : counter link (master): cur_hour/cur_min in; set_active,
//               field_sel, load, load_hour, load_min, load_sec out
module clock_time_set_ctrl import clock_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 50000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_mode,
  input  logic                  btn_inc,
  clock_time_set_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic mode_level, mode_press;
  logic inc_level, inc_press;
  logic inc_pulse;

  state_e            state_q, state_d;
  logic [HOUR_W-1:0] edit_hour_q, edit_hour_d;
  logic [MIN_W-1:0]  edit_min_q, edit_min_d;
  logic [HOUR_W-1:0] load_hour_q, load_hour_d;
  logic [MIN_W-1:0]  load_min_q, load_min_d;
  logic              set_active_q, set_active_d;
  logic [1:0]        field_sel_q, field_sel_d;
  logic              load_q, load_d;
  logic [CNT_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              rep_q, rep_d;
  logic [CNT_W-1:0]  idle_q, idle_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mode_btn (
    .clk(clk), .rst(rst), .btn_raw(btn_mode), .level(mode_level), .press(mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_inc_btn (
    .clk(clk), .rst(rst), .btn_raw(btn_inc), .level(inc_level), .press(inc_press)
  );

  assign inc_pulse = inc_press | rep_q;

  always_comb begin
    // Auto-repeat: counter restarts at 1 on the press pulse so the first
    // repeat lands exactly REPEAT_CYCLES after it, then every REPEAT_CYCLES.
    rep_d     = inc_level && (rep_cnt_q == REP_LAST);
    rep_cnt_d = rep_cnt_q + 1'b1;
    if (!inc_level) begin
      rep_cnt_d = '0;
    end else if (inc_press) begin
      rep_cnt_d = CNT_W'(1);
    end else if (rep_cnt_q == REP_LAST) begin
      rep_cnt_d = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    load_hour_d = load_hour_q;
    load_min_d  = load_min_q;
    idle_d      = idle_q + 1'b1;

    // Mode is checked first so a coincident inc pulse is dropped.
    unique case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d     = SET_HOUR;
          edit_hour_d = bus.cur_hour;
          edit_min_d  = bus.cur_min;
        end
      end
      SET_HOUR: begin
        if (mode_press) begin
          state_d = SET_MIN;
        end else if (inc_pulse) begin
          edit_hour_d = (edit_hour_q == MAX_HOUR) ? '0 : edit_hour_q + 1'b1;
        end else if (idle_q == TO_LAST) begin
          state_d = RUN;
        end
      end
      SET_MIN: begin
        if (mode_press) begin
          state_d = COMMIT;
        end else if (inc_pulse) begin
          edit_min_d = (edit_min_q == MAX_MIN) ? '0 : edit_min_q + 1'b1;
        end else if (idle_q == TO_LAST) begin
          state_d = RUN;
        end
      end
      COMMIT: begin
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (mode_press || inc_pulse || (state_d != state_q) || (state_q == RUN)) begin
      idle_d = '0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    set_active_d = (state_d != RUN);
    load_d       = (state_d == COMMIT);
    field_sel_d  = FSEL_NONE;
    if (state_d == SET_HOUR) field_sel_d = FSEL_HOUR;
    if (state_d == SET_MIN)  field_sel_d = FSEL_MIN;
    if (load_d) begin
      load_hour_d = edit_hour_q;
      load_min_d  = edit_min_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      edit_hour_q  <= '0;
      edit_min_q   <= '0;
      load_hour_q  <= '0;
      load_min_q   <= '0;
      set_active_q <= 1'b0;
      field_sel_q  <= FSEL_NONE;
      load_q       <= 1'b0;
      rep_cnt_q    <= '0;
      rep_q        <= 1'b0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      edit_hour_q  <= edit_hour_d;
      edit_min_q   <= edit_min_d;
      load_hour_q  <= load_hour_d;
      load_min_q   <= load_min_d;
      set_active_q <= set_active_d;
      field_sel_q  <= field_sel_d;
      load_q       <= load_d;
      rep_cnt_q    <= rep_cnt_d;
      rep_q        <= rep_d;
      idle_q       <= idle_d;
    end
  end

  assign bus.set_active = set_active_q;
  assign bus.field_sel  = field_sel_q;
  assign bus.load       = load_q;
  assign bus.load_hour  = load_hour_q;
  assign bus.load_min   = load_min_q;
  assign bus.load_sec   = '0;

endmodule
